axis_fifo_rr_arbiter: RTL and testbench
=======================================

Name: axis_fifo_rr_arbiter

Overview:
- Packet-aware round-robin arbiter draining NUM_IN upstream AXIS FIFO outputs onto one shared AXIS stream.
- Typical use: merging per-source FIFOs (e.g. several detector/demod result streams) before a single DMA or downstream consumer.
- Holds a grant until the granted input delivers tlast, or until an optional beat budget expires.
- Output is a single registered stage with tvalid/tready backpressure.

Parameters:
- NUM_IN, 4, number of requesters (>=2).
- DATA_WIDTH, 16, tdata width per input.
- USER_WIDTH, 1, tuser width per input (>=1).
- MAX_BURST, 0, beats per grant before a forced switch; 0 = unlimited (switch only on tlast).
- ID_WIDTH, derived = max(1, $clog2(NUM_IN)), width of the source id.

Ports:
- clk_i  in  1  single clock for the whole block.
- reset_i  in  1  synchronous, active-high reset.
- s_axis_in_tdata  in  NUM_IN*DATA_WIDTH  packed; input k occupies bits [k*DATA_WIDTH +: DATA_WIDTH].
- s_axis_in_tuser  in  NUM_IN*USER_WIDTH  packed, same layout as tdata.
- s_axis_in_tlast  in  NUM_IN  per-input end of packet.
- s_axis_in_tvalid  in  NUM_IN  per-input valid.
- s_axis_in_tready  out  NUM_IN  per-input ready; one-hot or zero.
- m_axis_out_tdata  out  DATA_WIDTH  registered.
- m_axis_out_tuser  out  USER_WIDTH  registered.
- m_axis_out_tlast  out  1  registered copy of the granted input's tlast.
- m_axis_out_tid  out  ID_WIDTH  index of the source of the current beat.
- m_axis_out_tvalid  out  1  registered.
- m_axis_out_tready  in  1  downstream ready.
- busy_o  out  1  high while in state GRANT.

Behaviour:
- Reset:
  - All m_axis_out_* outputs = 0; s_axis_in_tready = 0; busy_o = 0.
  - state = IDLE; beat counter = 0; last_grant = NUM_IN-1, so input 0 has first priority.
  - Reset mid-packet abandons the packet. Outputs are 0 on the cycle after reset is sampled. No partial-packet recovery.
- State IDLE:
  - s_axis_in_tready = 0.
  - If any tvalid is high: grant <= first input with tvalid high, searching (last_grant+1) mod NUM_IN upward with wrap. Go to GRANT next cycle. busy_o rises with the state.
  - If no tvalid is high: stay in IDLE.
- State GRANT:
  - s_axis_in_tready[grant] = (!m_axis_out_tvalid || m_axis_out_tready). All other ready bits = 0.
  - Input handshake = tvalid[grant] && tready[grant]. On a handshake:
    - Output register loads tdata/tuser/tlast of input grant.
    - m_axis_out_tid <= grant; m_axis_out_tvalid <= 1; counter += 1.
  - If there is no handshake and m_axis_out_tready = 1: m_axis_out_tvalid <= 0.
  - A handshake with tlast = 1 ends the grant: last_grant <= grant, counter <= 0, go to IDLE.
  - If MAX_BURST > 0, a handshake that brings the counter to MAX_BURST also ends the grant, even without tlast. m_axis_out_tlast is not forced high in that case.
  - A granted input that drops tvalid mid-packet keeps its grant; the arbiter waits indefinitely.
- Throughput and latency:
  - Input beat to m_axis_out_tvalid: 1 cycle.
  - Sustained rate inside a packet: 1 beat/cycle while m_axis_out_tready = 1.
  - Exactly one bubble cycle (the IDLE arbitration cycle) between grants.
- Output stability: m_axis_out_* are held stable while m_axis_out_tvalid && !m_axis_out_tready.
- Counter: width $clog2(MAX_BURST+1). Unused (held at 0) when MAX_BURST = 0.
- Fairness: a requester waits at most NUM_IN-1 grants.
- Simultaneous events:
  - In IDLE, the arbitration decision uses the tvalid values of that cycle.
  - The output register may drain (m_axis_out_tready) and refill (new handshake) in the same cycle.
- Inputs connect directly to FIFO outputs with standard AXIS semantics. Unconnected inputs are tied tvalid = 0.

Test Plan:
- Reset then all 4 inputs valid with 2-beat packets (data k*16+n) -> output order src 0,1,2,3. Each packet contiguous, tid correct, tlast on beat 2, one bubble between packets.
- Only input 2 valid, 5-beat packet, m_axis_out_tready = 1 -> first out beat 2 cycles after tvalid (IDLE + GRANT). Then 1 beat/cycle; busy_o falls the cycle after the tlast handshake.
- Downstream ready toggles 1,0,0,1 during a packet -> no beat lost or duplicated. Data held stable while stalled; s_axis_in_tready[grant] low on stall cycles.
- MAX_BURST = 3, inputs 0 and 1 each send an 8-beat packet -> beats interleave 3/3/3/3/2/2. m_axis_out_tlast high only on the true last beats.
- Assert reset_i for 1 cycle mid-packet of input 1 -> next cycle m_axis_out_tvalid = 0 and busy_o = 0. The following grant goes to input 0 when 0 and 1 are both valid.
- Input 3 drops tvalid for 4 cycles mid-packet while input 0 is valid -> grant stays on 3, and input 0 sees tready = 0 throughout.

Source files
------------

// File: rtl/axis_fifo_rr_arbiter.sv
// Packet-aware round-robin arbiter merging NUM_IN AXI-Stream FIFO outputs onto one
// registered AXI-Stream output; a grant is held until tlast or an optional beat budget.
module axis_fifo_rr_arbiter #(
    parameter  int NUM_IN     = 4,
    parameter  int DATA_WIDTH = 16,
    parameter  int USER_WIDTH = 1,
    parameter  int MAX_BURST  = 0,
    localparam int ID_WIDTH   = (NUM_IN > 2) ? $clog2(NUM_IN) : 1
) (
    input  logic                         clk_i,
    input  logic                         reset_i,
    input  logic [NUM_IN*DATA_WIDTH-1:0] s_axis_in_tdata,
    input  logic [NUM_IN*USER_WIDTH-1:0] s_axis_in_tuser,
    input  logic [NUM_IN-1:0]            s_axis_in_tlast,
    input  logic [NUM_IN-1:0]            s_axis_in_tvalid,
    output logic [NUM_IN-1:0]            s_axis_in_tready,
    output logic [DATA_WIDTH-1:0]        m_axis_out_tdata,
    output logic [USER_WIDTH-1:0]        m_axis_out_tuser,
    output logic                         m_axis_out_tlast,
    output logic [ID_WIDTH-1:0]          m_axis_out_tid,
    output logic                         m_axis_out_tvalid,
    input  logic                         m_axis_out_tready,
    output logic                         busy_o
);

    localparam int CNT_WIDTH = (MAX_BURST > 0) ? $clog2(MAX_BURST + 1) : 1;

    typedef enum logic {
        IDLE,
        GRANT
    } state_t;

    state_t               state_q, state_d;
    logic [ID_WIDTH-1:0]  grant_q, grant_d;
    logic [ID_WIDTH-1:0]  last_grant_q;
    logic [ID_WIDTH-1:0]  arb_idx;
    logic [ID_WIDTH-1:0]  cand;
    logic                 arb_found;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 out_ready;
    logic                 hs;
    logic                 burst_done;
    logic                 end_grant;

    logic [DATA_WIDTH-1:0] in_data [NUM_IN];
    logic [USER_WIDTH-1:0] in_user [NUM_IN];

    for (genvar k = 0; k < NUM_IN; k++) begin : g_unpack
        assign in_data[k] = s_axis_in_tdata[k*DATA_WIDTH +: DATA_WIDTH];
        assign in_user[k] = s_axis_in_tuser[k*USER_WIDTH +: USER_WIDTH];
    end

    // The output register can accept a new beat when empty or draining this cycle.
    assign out_ready  = !m_axis_out_tvalid || m_axis_out_tready;
    assign hs         = (state_q == GRANT) && s_axis_in_tvalid[grant_q] && out_ready;
    assign burst_done = (MAX_BURST > 0) && (cnt_q == CNT_WIDTH'(MAX_BURST - 1));
    assign end_grant  = hs && (s_axis_in_tlast[grant_q] || burst_done);
    assign busy_o     = (state_q == GRANT);

    // Search starts just after the previous winner and wraps, giving round-robin fairness.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path infers a latch.
        arb_found = 1'b0;
        arb_idx   = last_grant_q;
        cand      = '0;
        for (int i = 1; i <= NUM_IN; i++) begin
            cand = ID_WIDTH'((int'(last_grant_q) + i) % NUM_IN);
            if (!arb_found && s_axis_in_tvalid[cand]) begin
                arb_found = 1'b1;
                arb_idx   = cand;
            end
        end
    end

    always_comb begin
        state_d          = state_q;
        grant_d          = grant_q;
        s_axis_in_tready = '0;
        case (state_q)
            IDLE: begin
                if (arb_found) begin
                    state_d = GRANT;
                    grant_d = arb_idx;
                end
            end
            GRANT: begin
                s_axis_in_tready[grant_q] = out_ready;
                if (end_grant) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments so all registers update together.
        if (reset_i) begin
            state_q <= IDLE;
            grant_q <= '0;
        end else begin
            state_q <= state_d;
            grant_q <= grant_d;
        end
    end

    // last_grant resets to the top index so input 0 wins the first arbitration.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            m_axis_out_tdata  <= '0;
            m_axis_out_tuser  <= '0;
            m_axis_out_tlast  <= 1'b0;
            m_axis_out_tid    <= '0;
            m_axis_out_tvalid <= 1'b0;
            last_grant_q      <= ID_WIDTH'(NUM_IN - 1);
            cnt_q             <= '0;
        end else if (hs) begin
            m_axis_out_tdata  <= in_data[grant_q];
            m_axis_out_tuser  <= in_user[grant_q];
            m_axis_out_tlast  <= s_axis_in_tlast[grant_q];
            m_axis_out_tid    <= grant_q;
            m_axis_out_tvalid <= 1'b1;
            if (end_grant) begin
                last_grant_q <= grant_q;
                cnt_q        <= '0;
            end else if (MAX_BURST > 0) begin
                cnt_q <= cnt_q + 1'b1;
            end
        end else if (m_axis_out_tready) begin
            m_axis_out_tvalid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_axis_fifo_rr_arbiter.sv
// Directed bench for axis_fifo_rr_arbiter: one instance with unlimited bursts and one
// with MAX_BURST = 3, fed by simple FIFO-like packet sources.
module tb_axis_fifo_rr_arbiter;

    localparam int N  = 4;
    localparam int DW = 16;
    localparam int UW = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic            reset_i;
    logic [N*DW-1:0] s_tdata;
    logic [N*UW-1:0] s_tuser;
    logic [N-1:0]    s_tlast;
    logic [N-1:0]    a_tvalid, b_tvalid, a_tready, b_tready;
    logic [DW-1:0]   a_mdata, b_mdata;
    logic [UW-1:0]   a_muser, b_muser;
    logic            a_mlast, b_mlast, a_mvalid, b_mvalid, a_busy, b_busy;
    logic [1:0]      a_mid, b_mid;
    logic            mrdy;

    axis_fifo_rr_arbiter #(.NUM_IN(N), .DATA_WIDTH(DW), .USER_WIDTH(UW), .MAX_BURST(0)) dut_a (
        .clk_i(clk), .reset_i(reset_i),
        .s_axis_in_tdata(s_tdata), .s_axis_in_tuser(s_tuser), .s_axis_in_tlast(s_tlast),
        .s_axis_in_tvalid(a_tvalid), .s_axis_in_tready(a_tready),
        .m_axis_out_tdata(a_mdata), .m_axis_out_tuser(a_muser), .m_axis_out_tlast(a_mlast),
        .m_axis_out_tid(a_mid), .m_axis_out_tvalid(a_mvalid), .m_axis_out_tready(mrdy),
        .busy_o(a_busy)
    );

    axis_fifo_rr_arbiter #(.NUM_IN(N), .DATA_WIDTH(DW), .USER_WIDTH(UW), .MAX_BURST(3)) dut_b (
        .clk_i(clk), .reset_i(reset_i),
        .s_axis_in_tdata(s_tdata), .s_axis_in_tuser(s_tuser), .s_axis_in_tlast(s_tlast),
        .s_axis_in_tvalid(b_tvalid), .s_axis_in_tready(b_tready),
        .m_axis_out_tdata(b_mdata), .m_axis_out_tuser(b_muser), .m_axis_out_tlast(b_mlast),
        .m_axis_out_tid(b_mid), .m_axis_out_tvalid(b_mvalid), .m_axis_out_tready(mrdy),
        .busy_o(b_busy)
    );

    logic [15:0] src_data [N][8];
    int          src_len  [N];
    int          src_ptr  [N];
    bit          hold     [N];
    bit          sel;
    logic [18:0] log_q [$];
    logic [N-1:0] hs_v;
    logic [12:0] vh;
    int          checks = 0;
    int          errors = 0;

    int exp_src  [16] = '{0,0,0,1,1,1,0,0,0,1,1,1,0,0,1,1};
    int exp_beat [16] = '{0,1,2,0,1,2,3,4,5,3,4,5,6,7,6,7};

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [18:0] enc(input int id, input int last, input int d);
        return {id[1:0], last[0], d[15:0]};
    endfunction

    task automatic check_log(input string tag, input int idx, input logic [18:0] exp);
        if (idx < log_q.size()) check(tag, 32'(log_q[idx]), 32'(exp));
        else                    check(tag, 'x, 32'(exp));
    endtask

    // Sources present beats FIFO-style; sel routes their tvalid to one instance only.
    task automatic drive();
        for (int k = 0; k < N; k++) begin
            int p;
            bit v;
            p = (src_ptr[k] < src_len[k]) ? src_ptr[k] : 0;
            v = !hold[k] && (src_ptr[k] < src_len[k]);
            s_tdata[k*DW +: DW] = src_data[k][p];
            s_tuser[k]  = (src_ptr[k] == 0);
            s_tlast[k]  = (src_ptr[k] == src_len[k] - 1);
            a_tvalid[k] = !sel && v;
            b_tvalid[k] = sel && v;
        end
    endtask

    task automatic clear_sources();
        for (int k = 0; k < N; k++) begin
            src_len[k] = 0;
            src_ptr[k] = 0;
            hold[k]    = 1'b0;
            for (int i = 0; i < 8; i++) src_data[k][i] = '0;
        end
    endtask

    task automatic load(input int k, input int n, input int base);
        for (int i = 0; i < n; i++) src_data[k][i] = 16'(base + i);
        src_len[k] = n;
        src_ptr[k] = 0;
    endtask

    // One clock: sample handshakes before the edge, advance sources after it.
    task automatic step();
        drive();
        #1;
        hs_v = sel ? (b_tready & b_tvalid) : (a_tready & a_tvalid);
        if (!reset_i && mrdy) begin
            if (sel && b_mvalid)       log_q.push_back({b_mid, b_mlast, b_mdata});
            else if (!sel && a_mvalid) log_q.push_back({a_mid, a_mlast, a_mdata});
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) if (hs_v[k]) src_ptr[k]++;
        drive();
        #1;
    endtask

    initial begin
        reset_i = 1'b1;
        mrdy    = 1'b1;
        sel     = 1'b0;
        clear_sources();
        step();
        step();
        reset_i = 1'b0;
        check("rst_mvalid", 32'(a_mvalid), 0);
        check("rst_busy", 32'(a_busy), 0);
        check("rst_tready", 32'(a_tready), 0);
        check("rst_mdata", 32'(a_mdata), 0);
        check("rst_mid", 32'(a_mid), 0);
        check("rst_b_mvalid", 32'(b_mvalid), 0);

        // All four inputs with 2-beat packets: order 0,1,2,3 with one bubble between.
        log_q.delete();
        for (int k = 0; k < N; k++) load(k, 2, k * 16);
        vh = '0;
        for (int i = 0; i < 13; i++) begin
            step();
            vh = {vh[11:0], a_mvalid};
        end
        check("rr_valid_pattern", 32'(vh), 32'(13'b0110110110110));
        check("rr_count", log_q.size(), 8);
        for (int i = 0; i < 8; i++) check_log("rr_beat", i, enc(i / 2, i % 2, (i / 2) * 16 + i % 2));

        // Single input 2, 5-beat packet: 2-cycle latency, then 1 beat/cycle.
        clear_sources();
        log_q.delete();
        load(2, 5, 32);
        step();
        check("lat_e1_mvalid", 32'(a_mvalid), 0);
        check("lat_e1_busy", 32'(a_busy), 1);
        step();
        check("lat_e2_mvalid", 32'(a_mvalid), 1);
        check("lat_e2_mdata", 32'(a_mdata), 'h20);
        check("lat_e2_mid", 32'(a_mid), 2);
        step();
        step();
        step();
        check("lat_e5_busy", 32'(a_busy), 1);
        check("lat_e5_mdata", 32'(a_mdata), 'h23);
        step();
        check("lat_e6_mdata", 32'(a_mdata), 'h24);
        check("lat_e6_mlast", 32'(a_mlast), 1);
        check("lat_e6_busy", 32'(a_busy), 0);
        step();
        check("lat_drain_mvalid", 32'(a_mvalid), 0);
        check("lat_count", log_q.size(), 5);

        // Downstream ready 1,0,0,1 during a 4-beat packet on input 1.
        clear_sources();
        log_q.delete();
        load(1, 4, 16);
        step();
        step();
        step();
        check("stall_pre_mdata", 32'(a_mdata), 'h11);
        mrdy = 1'b0;
        drive();
        #1;
        check("stall_tready_0", 32'(a_tready), 0);
        for (int i = 0; i < 2; i++) begin
            step();
            check("stall_hold_mdata", 32'(a_mdata), 'h11);
            check("stall_hold_mvalid", 32'(a_mvalid), 1);
            check("stall_hold_tready", 32'(a_tready), 0);
        end
        mrdy = 1'b1;
        step();
        check("stall_resume_mdata", 32'(a_mdata), 'h12);
        step();
        step();
        check("stall_count", log_q.size(), 4);
        for (int i = 0; i < 4; i++) check_log("stall_beat", i, enc(1, (i == 3) ? 1 : 0, 16 + i));

        // MAX_BURST = 3 instance: two 8-beat packets interleave 3/3/3/3/2/2.
        sel = 1'b1;
        clear_sources();
        log_q.delete();
        load(0, 8, 0);
        load(1, 8, 16);
        for (int i = 0; i < 26; i++) step();
        check("burst_count", log_q.size(), 16);
        for (int i = 0; i < 16; i++)
            check_log("burst_beat", i, enc(exp_src[i], (exp_beat[i] == 7) ? 1 : 0, exp_src[i] * 16 + exp_beat[i]));

        // Reset mid-packet of input 1, then input 0 wins against input 1.
        sel = 1'b0;
        clear_sources();
        log_q.delete();
        load(1, 4, 16);
        step();
        step();
        step();
        check("mid_rst_pre_mid", 32'(a_mid), 1);
        check("mid_rst_pre_busy", 32'(a_busy), 1);
        reset_i = 1'b1;
        step();
        reset_i = 1'b0;
        check("mid_rst_mvalid", 32'(a_mvalid), 0);
        check("mid_rst_busy", 32'(a_busy), 0);
        check("mid_rst_tready", 32'(a_tready), 0);
        clear_sources();
        log_q.delete();
        load(0, 2, 0);
        load(1, 2, 16);
        step();
        step();
        check("post_rst_mvalid", 32'(a_mvalid), 1);
        check("post_rst_mid", 32'(a_mid), 0);
        check("post_rst_mdata", 32'(a_mdata), 0);
        for (int i = 0; i < 5; i++) step();
        check("post_rst_count", log_q.size(), 4);

        // Input 3 pauses for 4 cycles mid-packet; input 0 must stay locked out.
        clear_sources();
        log_q.delete();
        load(3, 4, 48);
        step();
        step();
        check("pause_first_mid", 32'(a_mid), 3);
        hold[3] = 1'b1;
        load(0, 2, 0);
        drive();
        #1;
        for (int i = 0; i < 4; i++) begin
            check("pause_tready", 32'(a_tready), 32'(4'b1000));
            check("pause_busy", 32'(a_busy), 1);
            step();
        end
        hold[3] = 1'b0;
        for (int i = 0; i < 7; i++) step();
        check("pause_count", log_q.size(), 6);
        for (int i = 0; i < 4; i++) check_log("pause_beat3", i, enc(3, (i == 3) ? 1 : 0, 48 + i));
        check_log("pause_beat0_0", 4, enc(0, 0, 0));
        check_log("pause_beat0_1", 5, enc(0, 1, 1));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
